// File: rtl/lc3_ctrl_pkg.sv
// LC-3 sequencer shared definitions: state codes, opcodes, mux/ALU encodings.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package lc3_ctrl_pkg;

    // Default number of cycles a memory state waits for mem_ack before the
    // sequencer gives up and halts with a bus error.
    localparam int MEM_WAIT_MAX_DEFAULT = 15;

    // Sequencer states. Kept as plain 4-bit constants so the encoding stays
    // stable for anything that probes the state register directly.
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_F0   = 4'd1;
    localparam logic [3:0] S_F1   = 4'd2;
    localparam logic [3:0] S_F2   = 4'd3;
    localparam logic [3:0] S_D    = 4'd4;
    localparam logic [3:0] S_ALU  = 4'd5;
    localparam logic [3:0] S_BR   = 4'd6;
    localparam logic [3:0] S_JMP  = 4'd7;
    localparam logic [3:0] S_LD0  = 4'd8;
    localparam logic [3:0] S_LD1  = 4'd9;
    localparam logic [3:0] S_LD2  = 4'd10;
    localparam logic [3:0] S_ST0  = 4'd11;
    localparam logic [3:0] S_ST1  = 4'd12;
    localparam logic [3:0] S_ST2  = 4'd13;
    localparam logic [3:0] S_HALT = 4'd14;

    // Opcodes held in IR[15:12].
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;

    // PC input mux.
    localparam logic [1:0] SELPC_INC  = 2'd0;
    localparam logic [1:0] SELPC_ADDR = 2'd1;
    localparam logic [1:0] SELPC_BUS  = 2'd2;

    // Address adder operand 2 mux.
    localparam logic [1:0] SELEAB2_ZERO = 2'd0;
    localparam logic [1:0] SELEAB2_OFF9 = 2'd2;

    // Address adder operand 1 mux.
    localparam logic SELEAB1_PC  = 1'b0;
    localparam logic SELEAB1_SR1 = 1'b1;

    // MDR input mux.
    localparam logic SELMDR_BUS = 1'b0;
    localparam logic SELMDR_MEM = 1'b1;

    // ALU function select.
    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_AND  = 2'd2;
    localparam logic [1:0] ALU_NOT  = 2'd3;

    // ALU function for an operate-class opcode; anything else passes SR1.
    function automatic logic [1:0] alu_ctl_for(input logic [3:0] opcode);
        case (opcode)
            OP_ADD:  alu_ctl_for = ALU_ADD;
            OP_AND:  alu_ctl_for = ALU_AND;
            OP_NOT:  alu_ctl_for = ALU_NOT;
            default: alu_ctl_for = ALU_PASS;
        endcase
    endfunction

    // States that hold a memory request open until mem_ack.
    function automatic logic is_mem_wait(input logic [3:0] st);
        is_mem_wait = (st == S_F1) || (st == S_LD1) || (st == S_ST2);
    endfunction

endpackage

// File: rtl/lc3_br_eval.sv
// Branch condition evaluator: taken when any requested NZP flag is set.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: nzp_mask = IR[11:9] (n,z,p request bits); n/z/p = condition codes;
//        taken = branch condition satisfied.
module lc3_br_eval (
    input  logic [2:0] nzp_mask,
    input  logic       n,
    input  logic       z,
    input  logic       p,
    output logic       taken
);

    assign taken = (nzp_mask[2] & n) | (nzp_mask[1] & z) | (nzp_mask[0] & p);

endmodule

// File: rtl/lc3_seq_ctrl.sv
// Multi-cycle LC-3 control sequencer: fetch/decode/execute for ADD, AND, NOT,
//   BR, JMP, LD, ST; every other opcode or a memory timeout halts.
// Latency: ALU/BR/JMP 5 cycles F0->F0, LD/ST 7 cycles, plus extra ack wait cycles.
// Backpressure: memory states hold mem_req until mem_ack, bounded by MEM_WAIT_MAX.
// Ports: clk/reset (async, active-low); run starts fetch from IDLE; IR and N/Z/P
//   come from the datapath; mem_req/memWE/mem_ack form the memory handshake;
//   ld*/gate*/sel*/aluControl/DR/SR1/SR2 steer the datapath; halted/bus_err
//   report a stopped sequencer.
module lc3_seq_ctrl
    import lc3_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] IR,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        memWE,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        ldIR,
    output logic        ldPC,
    output logic        ldReg,
    output logic        flagWE,
    output logic        gatePC,
    output logic        gateMDR,
    output logic        gateALU,
    output logic        gateMARMUX,
    output logic [1:0]  selPC,
    output logic        selEAB1,
    output logic [1:0]  selEAB2,
    output logic        selMDR,
    output logic [1:0]  aluControl,
    output logic [2:0]  DR,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    output logic        halted,
    output logic        bus_err
);

    // The wait counter only ever needs to reach MEM_WAIT_MAX-1.
    localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MEM_WAIT_MAX > 0) ? (MEM_WAIT_MAX - 1) : 0);

    logic [3:0]        state;
    logic [3:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              err_q;
    logic              set_err;
    logic              in_wait;
    logic              timeout_hit;
    logic              br_taken;
    logic [3:0]        opcode;

    // Immediate/mode bits are datapath concerns; the sequencer never looks at them.
    logic unused_ir;
    assign unused_ir = ^IR[5:3];

    assign opcode  = IR[15:12];
    assign in_wait = is_mem_wait(state);

    // Timeout fires on the last permitted wait cycle if no ack arrives in it,
    // so the request is held for exactly MEM_WAIT_MAX cycles before halting.
    assign timeout_hit = (MEM_WAIT_MAX != 0) && (wait_cnt == WAIT_LAST);

    lc3_br_eval u_br_eval (
        .nzp_mask (IR[11:9]),
        .n        (N),
        .z        (Z),
        .p        (P),
        .taken    (br_taken)
    );

    // ------------------------------------------------------------------
    // State, wait counter and bus-error latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            // Every wait state is entered from a non-wait state, so clearing
            // outside the wait states restarts the count on each entry.
            if (in_wait && !mem_ack) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        set_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nxt = S_F0;
                end
            end
            S_F0: state_nxt = S_F1;
            S_F1, S_LD1, S_ST2: begin
                if (mem_ack) begin
                    case (state)
                        S_F1:    state_nxt = S_F2;
                        S_LD1:   state_nxt = S_LD2;
                        default: state_nxt = S_F0;
                    endcase
                end else if (timeout_hit) begin
                    state_nxt = S_HALT;
                    set_err   = 1'b1;
                end
            end
            S_F2: state_nxt = S_D;
            S_D: begin
                case (opcode)
                    OP_ADD, OP_AND, OP_NOT: state_nxt = S_ALU;
                    OP_BR:                  state_nxt = S_BR;
                    OP_JMP:                 state_nxt = S_JMP;
                    OP_LD:                  state_nxt = S_LD0;
                    OP_ST:                  state_nxt = S_ST0;
                    default:                state_nxt = S_HALT;
                endcase
            end
            S_ALU, S_BR, S_JMP, S_LD2: state_nxt = S_F0;
            S_LD0: state_nxt = S_LD1;
            S_ST0: state_nxt = S_ST1;
            S_ST1: state_nxt = S_ST2;
            S_HALT: state_nxt = S_HALT;
            // The one unused encoding parks safely in HALT.
            default: state_nxt = S_HALT;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: Moore on state and IR fields; only the MDR load in
    // the read states is qualified by mem_ack.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req    = 1'b0;
        memWE      = 1'b0;
        ldMAR      = 1'b0;
        ldMDR      = 1'b0;
        ldIR       = 1'b0;
        ldPC       = 1'b0;
        ldReg      = 1'b0;
        flagWE     = 1'b0;
        gatePC     = 1'b0;
        gateMDR    = 1'b0;
        gateALU    = 1'b0;
        gateMARMUX = 1'b0;
        selPC      = SELPC_INC;
        selEAB1    = SELEAB1_PC;
        selEAB2    = SELEAB2_ZERO;
        selMDR     = SELMDR_BUS;
        aluControl = ALU_PASS;
        DR         = 3'd0;
        SR1        = 3'd0;
        SR2        = 3'd0;
        halted     = 1'b0;
        bus_err    = 1'b0;
        case (state)
            S_F0: begin
                // MAR <- PC, PC <- PC+1
                gatePC = 1'b1;
                ldMAR  = 1'b1;
                ldPC   = 1'b1;
                selPC  = SELPC_INC;
            end
            S_F1, S_LD1: begin
                mem_req = 1'b1;
                selMDR  = SELMDR_MEM;
                ldMDR   = mem_ack;
            end
            S_F2: begin
                gateMDR = 1'b1;
                ldIR    = 1'b1;
            end
            S_ALU: begin
                aluControl = alu_ctl_for(opcode);
                gateALU    = 1'b1;
                ldReg      = 1'b1;
                flagWE     = 1'b1;
                DR         = IR[11:9];
                SR1        = IR[8:6];
                SR2        = IR[2:0];
            end
            S_BR: begin
                // Adder output is steered to PC regardless; only the load is conditional.
                selPC   = SELPC_ADDR;
                selEAB1 = SELEAB1_PC;
                selEAB2 = SELEAB2_OFF9;
                ldPC    = br_taken;
            end
            S_JMP: begin
                SR1     = IR[8:6];
                selEAB1 = SELEAB1_SR1;
                selEAB2 = SELEAB2_ZERO;
                selPC   = SELPC_ADDR;
                ldPC    = 1'b1;
            end
            S_LD0, S_ST0: begin
                // MAR <- PC + offset9
                selEAB1    = SELEAB1_PC;
                selEAB2    = SELEAB2_OFF9;
                gateMARMUX = 1'b1;
                ldMAR      = 1'b1;
            end
            S_LD2: begin
                gateMDR = 1'b1;
                ldReg   = 1'b1;
                flagWE  = 1'b1;
                DR      = IR[11:9];
            end
            S_ST1: begin
                // MDR <- SR (source register lives in the DR field for ST)
                SR1        = IR[11:9];
                aluControl = ALU_PASS;
                gateALU    = 1'b1;
                ldMDR      = 1'b1;
                selMDR     = SELMDR_BUS;
            end
            S_ST2: begin
                mem_req = 1'b1;
                memWE   = 1'b1;
            end
            S_HALT: begin
                halted  = 1'b1;
                bus_err = err_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_lc3_seq_ctrl.sv
// Directed bench for lc3_seq_ctrl: reset, fetch/ALU, BR sweep, LD, ST,
//   illegal-opcode halt, reset mid-transaction and memory timeout.
// Inputs change at posedge+2; outputs are sampled at posedge+2 or +3.
module tb_lc3_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] IR;
    logic        N, Z, P;
    logic        mem_ack;
    logic        mem_req, memWE;
    logic        ldMAR, ldMDR, ldIR, ldPC, ldReg, flagWE;
    logic        gatePC, gateMDR, gateALU, gateMARMUX;
    logic [1:0]  selPC;
    logic        selEAB1;
    logic [1:0]  selEAB2;
    logic        selMDR;
    logic [1:0]  aluControl;
    logic [2:0]  DR, SR1, SR2;
    logic        halted, bus_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lc3_seq_ctrl #(.MEM_WAIT_MAX(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .IR         (IR),
        .N          (N),
        .Z          (Z),
        .P          (P),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .memWE      (memWE),
        .ldMAR      (ldMAR),
        .ldMDR      (ldMDR),
        .ldIR       (ldIR),
        .ldPC       (ldPC),
        .ldReg      (ldReg),
        .flagWE     (flagWE),
        .gatePC     (gatePC),
        .gateMDR    (gateMDR),
        .gateALU    (gateALU),
        .gateMARMUX (gateMARMUX),
        .selPC      (selPC),
        .selEAB1    (selEAB1),
        .selEAB2    (selEAB2),
        .selMDR     (selMDR),
        .aluControl (aluControl),
        .DR         (DR),
        .SR1        (SR1),
        .SR2        (SR2),
        .halted     (halted),
        .bus_err    (bus_err)
    );

    // All single-bit controls in one vector for compact expected values.
    logic [13:0] ctl;
    assign ctl = {mem_req, memWE, ldMAR, ldMDR, ldIR, ldPC, ldReg, flagWE,
                  gatePC, gateMDR, gateALU, gateMARMUX, halted, bus_err};
    logic [16:0] sels;
    assign sels = {selPC, selEAB1, selEAB2, selMDR, aluControl, DR, SR1, SR2};

    localparam logic [13:0] C_REQ   = 14'h2000;
    localparam logic [13:0] C_WE    = 14'h1000;
    localparam logic [13:0] C_LDMAR = 14'h0800;
    localparam logic [13:0] C_LDMDR = 14'h0400;
    localparam logic [13:0] C_LDIR  = 14'h0200;
    localparam logic [13:0] C_LDPC  = 14'h0100;
    localparam logic [13:0] C_LDREG = 14'h0080;
    localparam logic [13:0] C_FLAG  = 14'h0040;
    localparam logic [13:0] C_GPC   = 14'h0020;
    localparam logic [13:0] C_GMDR  = 14'h0010;
    localparam logic [13:0] C_GALU  = 14'h0008;
    localparam logic [13:0] C_GMMUX = 14'h0004;
    localparam logic [13:0] C_HALT  = 14'h0002;
    localparam logic [13:0] C_BERR  = 14'h0001;
    localparam logic [13:0] C_F0    = 14'h0920; // gatePC | ldMAR | ldPC

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Stimulus only: from an F0 cycle, acks the fetch at once and presents
    // the instruction; returns in the decode cycle.
    task automatic fetch(input logic [15:0] instr);
        step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        IR = instr;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b0; mem_ack = 1'b0; IR = 16'h0000;
        N = 1'b0; Z = 1'b0; P = 1'b0;
        #1;
        total++;
        if (ctl !== 14'h0) begin bad++; $display("FAIL reset_ctl: got %h want 0000", ctl); end
        total++;
        if (sels !== 17'h0) begin bad++; $display("FAIL reset_sels: got %h want 0", sels); end
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        step(); step();
        total++;
        if (ctl !== 14'h0) begin bad++; $display("FAIL idle_no_run: got %h want 0000", ctl); end
        run = 1'b1;
        step();
        run = 1'b0;
        total++;
        if (ctl !== C_F0 || selPC !== 2'd0) begin
            bad++; $display("FAIL start_f0: ctl %h selPC %0d want %h 0", ctl, selPC, C_F0);
        end
    endtask

    // Starts in F0 (cycle 1). ADD R0,R1,R2.
    task automatic test_alu();
        step();                       // cycle 2: F1
        mem_ack = 1'b1;
        #1;
        total++;
        if (ctl !== (C_REQ | C_LDMDR) || selMDR !== 1'b1) begin
            bad++; $display("FAIL alu_f1: ctl %h selMDR %b want %h 1", ctl, selMDR, C_REQ | C_LDMDR);
        end
        IR = 16'h1042;
        step();                       // cycle 3: F2
        mem_ack = 1'b0;
        #1;
        total++;
        if (ctl !== (C_GMDR | C_LDIR)) begin
            bad++; $display("FAIL alu_f2_ldir: got %h want %h", ctl, C_GMDR | C_LDIR);
        end
        step();                       // cycle 4: D, stray ack must be ignored
        mem_ack = 1'b1;
        #1;
        total++;
        if (ctl !== 14'h0) begin bad++; $display("FAIL alu_decode_quiet: got %h want 0000", ctl); end
        step();                       // cycle 5: ALU
        mem_ack = 1'b0;
        #1;
        total++;
        if (ctl !== (C_GALU | C_LDREG | C_FLAG)) begin
            bad++; $display("FAIL alu_exec_ctl: got %h want %h", ctl, C_GALU | C_LDREG | C_FLAG);
        end
        total++;
        if (aluControl !== 2'd1 || DR !== 3'd0 || SR1 !== 3'd1 || SR2 !== 3'd2) begin
            bad++; $display("FAIL alu_exec_fields: alu %0d DR %0d SR1 %0d SR2 %0d want 1 0 1 2",
                            aluControl, DR, SR1, SR2);
        end
        step();                       // cycle 6: next F0
        total++;
        if (ctl !== C_F0) begin bad++; $display("FAIL alu_back_f0: got %h want %h", ctl, C_F0); end
    endtask

    // Every nzp request mask against each single set condition code.
    task automatic test_br();
        logic [8:0]  ccs;
        logic [2:0]  cc;
        logic [2:0]  mk;
        logic        exp_taken;
        ccs = 9'b100_010_001;
        for (int c = 0; c < 3; c++) begin
            for (int m = 0; m < 8; m++) begin
                cc = ccs[8 - 3*c -: 3];
                mk = m[2:0];
                exp_taken = (mk & cc) != 3'b000;
                {N, Z, P} = cc;
                fetch({4'b0000, mk, 9'h005});
                step();               // BR
                total++;
                if (ldPC !== exp_taken) begin
                    bad++; $display("FAIL br_taken mask=%b nzp=%b: ldPC %b want %b", mk, cc, ldPC, exp_taken);
                end
                total++;
                if ((ctl & ~C_LDPC) !== 14'h0 || selPC !== 2'd1 || selEAB1 !== 1'b0 || selEAB2 !== 2'd2) begin
                    bad++; $display("FAIL br_state mask=%b nzp=%b: ctl %h selPC %0d eab1 %b eab2 %0d",
                                    mk, cc, ctl, selPC, selEAB1, selEAB2);
                end
                step();               // F0
            end
        end
        total++;
        if (ctl !== C_F0) begin bad++; $display("FAIL br_back_f0: got %h want %h", ctl, C_F0); end
        {N, Z, P} = 3'b000;
    endtask

    // LD R2, offset 5; ack arrives on the 4th request cycle.
    task automatic test_ld();
        fetch(16'h2405);
        step();                       // LD0, stray ack ignored
        mem_ack = 1'b1;
        #1;
        total++;
        if (ctl !== (C_GMMUX | C_LDMAR) || selEAB1 !== 1'b0 || selEAB2 !== 2'd2) begin
            bad++; $display("FAIL ld0: ctl %h eab1 %b eab2 %0d want %h 0 2", ctl, selEAB1, selEAB2, C_GMMUX | C_LDMAR);
        end
        mem_ack = 1'b0;
        step();                       // LD1 first request cycle
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            #1;
            total++;
            if (ctl !== ((i == 3) ? (C_REQ | C_LDMDR) : C_REQ)) begin
                bad++; $display("FAIL ld1_wait%0d: got %h want %h", i, ctl, (i == 3) ? (C_REQ | C_LDMDR) : C_REQ);
            end
            step();
        end
        mem_ack = 1'b0;
        #1;
        total++;
        if (ctl !== (C_GMDR | C_LDREG | C_FLAG) || DR !== 3'd2) begin
            bad++; $display("FAIL ld2: ctl %h DR %0d want %h 2", ctl, DR, C_GMDR | C_LDREG | C_FLAG);
        end
        step();
        total++;
        if (ctl !== C_F0) begin bad++; $display("FAIL ld_back_f0: got %h want %h", ctl, C_F0); end
    endtask

    // ST R3, offset 3; ack on the 2nd write cycle.
    task automatic test_st();
        logic flag_seen;
        flag_seen = 1'b0;
        fetch(16'h3603);
        flag_seen |= flagWE;
        step();                       // ST0
        flag_seen |= flagWE;
        total++;
        if (ctl !== (C_GMMUX | C_LDMAR)) begin
            bad++; $display("FAIL st0: got %h want %h", ctl, C_GMMUX | C_LDMAR);
        end
        step();                       // ST1
        flag_seen |= flagWE;
        total++;
        if (ctl !== (C_GALU | C_LDMDR) || SR1 !== 3'd3 || selMDR !== 1'b0 || aluControl !== 2'd0) begin
            bad++; $display("FAIL st1: ctl %h SR1 %0d selMDR %b alu %0d want %h 3 0 0",
                            ctl, SR1, selMDR, aluControl, C_GALU | C_LDMDR);
        end
        step();                       // ST2, no ack yet
        #1;
        flag_seen |= flagWE;
        total++;
        if (ctl !== (C_REQ | C_WE)) begin bad++; $display("FAIL st2_wait: got %h want %h", ctl, C_REQ | C_WE); end
        step();
        mem_ack = 1'b1;
        #1;
        flag_seen |= flagWE;
        total++;
        if (ctl !== (C_REQ | C_WE)) begin bad++; $display("FAIL st2_ack: got %h want %h", ctl, C_REQ | C_WE); end
        step();
        mem_ack = 1'b0;
        #1;
        total++;
        if (ctl !== C_F0) begin bad++; $display("FAIL st_back_f0: got %h want %h", ctl, C_F0); end
        total++;
        if (flag_seen !== 1'b0) begin bad++; $display("FAIL st_no_flagwe: saw %b want 0", flag_seen); end
    endtask

    task automatic test_halt_opcode();
        fetch(16'hF025);
        step();
        total++;
        if (ctl !== C_HALT) begin bad++; $display("FAIL halt_enter: got %h want %h", ctl, C_HALT); end
        run = 1'b1;
        repeat (3) step();
        total++;
        if (ctl !== C_HALT || sels !== 17'h0) begin
            bad++; $display("FAIL halt_sticky: ctl %h sels %h want %h 0", ctl, sels, C_HALT);
        end
        run = 1'b0;
    endtask

    // Starts in HALT; reset exits it, then reset is pulled mid-fetch.
    task automatic test_reset_mid();
        reset = 1'b0;
        #1;
        total++;
        if (ctl !== 14'h0) begin bad++; $display("FAIL reset_from_halt: got %h want 0000", ctl); end
        reset = 1'b1;
        step();
        run = 1'b1;
        step();                       // F0
        run = 1'b0;
        step();                       // F1
        #1;
        total++;
        if (ctl !== C_REQ) begin bad++; $display("FAIL mid_f1_req: got %h want %h", ctl, C_REQ); end
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (ctl !== 14'h0) begin bad++; $display("FAIL mid_reset_drop: got %h want 0000", ctl); end
        mem_ack = 1'b1;
        step();
        total++;
        if (ctl !== 14'h0) begin bad++; $display("FAIL mid_reset_noload: got %h want 0000", ctl); end
        mem_ack = 1'b0;
        reset = 1'b1;
        repeat (2) step();
        total++;
        if (ctl !== 14'h0 || sels !== 17'h0) begin
            bad++; $display("FAIL post_reset_idle: ctl %h sels %h want 0 0", ctl, sels);
        end
        run = 1'b1;
        step();
        run = 1'b0;
        total++;
        if (ctl !== C_F0) begin bad++; $display("FAIL post_reset_run: got %h want %h", ctl, C_F0); end
    endtask

    // Starts in F0; memory never acks the fetch.
    task automatic test_timeout();
        int req_cycles;
        req_cycles = 0;
        mem_ack = 1'b0;
        step();                       // F1, first request cycle
        for (int i = 0; i < 15; i++) begin
            if (ctl === C_REQ) req_cycles++;
            step();
        end
        total++;
        if (req_cycles != 15) begin bad++; $display("FAIL timeout_req_cycles: got %0d want 15", req_cycles); end
        total++;
        if (ctl !== (C_HALT | C_BERR)) begin
            bad++; $display("FAIL timeout_halt: got %h want %h", ctl, C_HALT | C_BERR);
        end
        run = 1'b1;
        mem_ack = 1'b1;
        repeat (2) step();
        total++;
        if (ctl !== (C_HALT | C_BERR)) begin
            bad++; $display("FAIL timeout_sticky: got %h want %h", ctl, C_HALT | C_BERR);
        end
        run = 1'b0;
        mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_br();
        test_ld();
        test_st();
        test_halt_opcode();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
